bus_arbiter: RTL and testbench

- Shares the single `bus_controller` between two requesters:
  - port 0: CPU core data/char/program accesses;
  - port 1: loader/debug engine that fills and inspects memory.
- Grants round-robin and latches the winner's command.
- Drives `mreq`/`mtype`/`addr`/`data_in` into `bus_controller` with the mreq low-gap its two-flop edge detector requires.
- Returns read data and a done pulse to the owner, and rejects mtype codes the bus controller would hang on.

---
 rtl/bus_arbiter_pkg.sv | 17 +
 rtl/bus_arbiter_rr_pick2.sv | 20 ++
 rtl/bus_arbiter.sv | 144 ++++++++++++++
 tb/tb_bus_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the bus arbiter and bus_controller: mtype codes and
// the legality test for them.
package bus_arbiter_pkg;

  localparam logic [2:0] MT_RDATA = 3'd0;
  localparam logic [2:0] MT_WDATA = 3'd1;
  localparam logic [2:0] MT_RCHAR = 3'd2;
  localparam logic [2:0] MT_WCHAR = 3'd3;
  localparam logic [2:0] MT_PROGN = 3'd4;
  localparam logic [2:0] MT_PROGP = 3'd5;

  // Codes 6 and 7 are reserved; bus_controller would hang on them.
  function automatic logic mtype_legal(input logic [2:0] t);
    return t < 3'd6;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick2.sv
// Two-input round-robin chooser: on a tie the port not granted last wins.
module rr_pick2 (
  input  logic       req0,
  input  logic       req1,
  input  logic       last,
  output logic [1:0] pick
);

  always_comb begin
    pick = 2'b00;
    if (req0 && req1) begin
      pick = last ? 2'b01 : 2'b10;
    end else if (req0) begin
      pick = 2'b01;
    end else if (req1) begin
      pick = 2'b10;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Shares one bus_controller between the CPU (port 0) and the loader/debug
// engine (port 1); the system top drives bus_controller.reset from ~rst_n.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int GAP_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [2:0]  type0,
  input  logic [2:0]  type1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [7:0]  wdata0,
  input  logic [7:0]  wdata1,
  output logic [1:0]  gnt,
  output logic        done0,
  output logic        done1,
  output logic        err,
  output logic [7:0]  rdata,
  output logic        mreq,
  output logic [2:0]  mtype,
  output logic [15:0] maddr,
  output logic [7:0]  mwdata,
  input  logic        mdone,
  input  logic [7:0]  mrdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  state_t      state, state_next;
  logic        last, last_next;
  logic [3:0]  gap_cnt, gap_cnt_next;
  logic [1:0]  pick;
  logic [1:0]  gnt_next;
  logic        done0_next, done1_next, err_next, mreq_next;
  logic [7:0]  rdata_next, mwdata_next;
  logic [2:0]  mtype_next;
  logic [15:0] maddr_next;

  rr_pick2 u_pick (
    .req0 (req0),
    .req1 (req1),
    .last (last),
    .pick (pick)
  );

  always_comb begin
    state_next   = state;
    last_next    = last;
    gap_cnt_next = gap_cnt;
    gnt_next     = gnt;
    done0_next   = 1'b0;
    done1_next   = 1'b0;
    err_next     = 1'b0;
    rdata_next   = rdata;
    mreq_next    = mreq;
    mtype_next   = mtype;
    maddr_next   = maddr;
    mwdata_next  = mwdata;

    case (state)
      IDLE: begin
        if (pick != 2'b00) begin
          gnt_next    = pick;
          mtype_next  = pick[1] ? type1  : type0;
          maddr_next  = pick[1] ? addr1  : addr0;
          mwdata_next = pick[1] ? wdata1 : wdata0;
          state_next  = ISSUE;
        end
      end
      ISSUE: begin
        if (mtype_legal(mtype)) begin
          mreq_next  = 1'b1;
          state_next = WAIT;
        end else begin
          done0_next   = gnt[0];
          done1_next   = gnt[1];
          err_next     = 1'b1;
          gnt_next     = 2'b00;
          gap_cnt_next = 4'd0;
          state_next   = GAP;
        end
      end
      WAIT: begin
        if (mdone) begin
          rdata_next   = mrdata;
          mreq_next    = 1'b0;
          gnt_next     = 2'b00;
          done0_next   = gnt[0];
          done1_next   = gnt[1];
          last_next    = gnt[1];
          gap_cnt_next = 4'd0;
          state_next   = GAP;
        end
      end
      GAP: begin
        // Keeps mreq low long enough for bus_controller's edge detector to re-arm.
        if (gap_cnt == GAP_LAST) begin
          gap_cnt_next = 4'd0;
          state_next   = IDLE;
        end else begin
          gap_cnt_next = gap_cnt + 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last    <= 1'b1;
      gap_cnt <= 4'd0;
      gnt     <= 2'b00;
      done0   <= 1'b0;
      done1   <= 1'b0;
      err     <= 1'b0;
      rdata   <= 8'h00;
      mreq    <= 1'b0;
      mtype   <= 3'd0;
      maddr   <= 16'h0000;
      mwdata  <= 8'h00;
    end else begin
      state   <= state_next;
      last    <= last_next;
      gap_cnt <= gap_cnt_next;
      gnt     <= gnt_next;
      done0   <= done0_next;
      done1   <= done1_next;
      err     <= err_next;
      rdata   <= rdata_next;
      mreq    <= mreq_next;
      mtype   <= mtype_next;
      maddr   <= maddr_next;
      mwdata  <= mwdata_next;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios followed by random
// traffic, all compared cycle by cycle against a transaction-timeline model.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  localparam int GAP = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [2:0]  type0 = 3'd0, type1 = 3'd0;
  logic [15:0] addr0 = 16'h0, addr1 = 16'h0;
  logic [7:0]  wdata0 = 8'h0, wdata1 = 8'h0;
  logic [1:0]  gnt;
  logic        done0, done1, err, mreq;
  logic [7:0]  rdata, mwdata;
  logic [2:0]  mtype;
  logic [15:0] maddr;
  logic        mdone = 1'b0;
  logic [7:0]  mrdata = 8'h0;

  int assert_count = 0;
  int fail_count = 0;

  bit         bus_hold = 1'b0;
  bit         fixed_mode = 1'b0;
  logic [7:0] fixed_data = 8'h00;
  int         stray_cnt = 0;
  int         rise_count = 0;
  int         legal_issues = 0;

  bus_arbiter #(.GAP_CYCLES(GAP)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req0   (req0),
    .req1   (req1),
    .type0  (type0),
    .type1  (type1),
    .addr0  (addr0),
    .addr1  (addr1),
    .wdata0 (wdata0),
    .wdata1 (wdata1),
    .gnt    (gnt),
    .done0  (done0),
    .done1  (done1),
    .err    (err),
    .rdata  (rdata),
    .mreq   (mreq),
    .mtype  (mtype),
    .maddr  (maddr),
    .mwdata (mwdata),
    .mdone  (mdone),
    .mrdata (mrdata)
  );

  initial begin
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assert_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int port, input logic [2:0] t,
                               input logic [15:0] a, input logic [7:0] w);
    if (port == 0) begin
      type0 = t; addr0 = a; wdata0 = w; req0 = 1'b1;
    end else begin
      type1 = t; addr1 = a; wdata1 = w; req1 = 1'b1;
    end
  endtask

  task automatic waitDone(input int port, input int budget, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!(port == 1 ? done1 : done0) && cycles < budget);
    checkOutput("done_seen", 32'(port == 1 ? done1 : done0), 32'd1);
  endtask

  task automatic waitAnyDone(input int budget, output logic [1:0] seen);
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!(done0 || done1) && c < budget);
    seen = {done1, done0};
    checkOutput("done_any_seen", 32'(done0 | done1), 32'd1);
  endtask

  task automatic waitMreq(input int budget);
    int c = 0;
    while (mreq !== 1'b1 && c < budget) begin
      @(negedge clk);
      c++;
    end
    checkOutput("mreq_rise_seen", 32'(mreq), 32'd1);
  endtask

  task automatic waitGnt(input int budget);
    int c = 0;
    while (gnt == 2'b00 && c < budget) begin
      @(negedge clk);
      c++;
    end
    checkOutput("gnt_seen", 32'(gnt != 2'b00), 32'd1);
  endtask

  // Bus slave: acks each fresh mreq rising edge after a random latency and
  // checks that mreq stayed low long enough before every new rise.
  initial begin : bus_model
    int  stray_seen = 0;
    int  lat = 0;
    int  low_run = 0;
    bit  busy = 1'b0;
    bit  seen_rise = 1'b0;
    bit  prev_mreq = 1'b0;
    forever begin
      @(negedge clk);
      mdone = 1'b0;
      if (!rst_n) begin
        busy = 1'b0; prev_mreq = 1'b0; seen_rise = 1'b0;
        low_run = 0; stray_seen = stray_cnt;
        continue;
      end
      if (mreq && !prev_mreq) begin
        rise_count++;
        if (seen_rise) checkOutput("mreq_low_gap", 32'(low_run >= GAP), 32'd1);
        seen_rise = 1'b1;
        busy = 1'b1;
        lat = $urandom_range(0, 3);
      end
      if (mreq) low_run = 0;
      else      low_run++;
      if (busy && !bus_hold) begin
        if (lat == 0) begin
          mdone  = 1'b1;
          mrdata = fixed_mode ? fixed_data : 8'($urandom);
          busy   = 1'b0;
        end else begin
          lat--;
        end
      end else if (!busy && stray_seen != stray_cnt) begin
        mdone  = 1'b1;
        mrdata = 8'($urandom);
        stray_seen = stray_cnt;
      end
      prev_mreq = mreq;
    end
  end

  // Reference model: tracks the current transaction as (owner, grant edge,
  // earliest next grant edge) and derives every registered output from it.
  initial begin : ref_model
    int          n = 0;
    int          owner = -1;
    int          grant_edge = 0;
    int          free_at = 0;
    int          last_port = 1;
    bit          legal = 1'b0;
    logic [2:0]  e_type = 3'd0;
    logic [15:0] e_addr = 16'h0;
    logic [7:0]  e_wdata = 8'h0, e_rdata = 8'h0;
    logic [1:0]  e_gnt;
    logic        e_done0, e_done1, e_err, e_mreq;
    forever begin
      @(posedge clk);
      n++;
      e_done0 = 1'b0; e_done1 = 1'b0; e_err = 1'b0;
      if (!rst_n) begin
        owner = -1; last_port = 1; free_at = 0; legal = 1'b0;
        e_type = 3'd0; e_addr = 16'h0; e_wdata = 8'h0; e_rdata = 8'h0;
      end else if (owner < 0) begin
        if (n >= free_at && (req0 || req1)) begin
          if (req0 && req1) owner = (last_port == 1) ? 0 : 1;
          else              owner = req0 ? 0 : 1;
          grant_edge = n;
          e_type  = (owner == 1) ? type1  : type0;
          e_addr  = (owner == 1) ? addr1  : addr0;
          e_wdata = (owner == 1) ? wdata1 : wdata0;
          legal   = (e_type < 3'd6);
        end
      end else if (n == grant_edge + 1) begin
        if (!legal) begin
          e_done0 = (owner == 0); e_done1 = (owner == 1); e_err = 1'b1;
          owner = -1;
          free_at = n + GAP + 1;
        end else begin
          legal_issues++;
        end
      end else if (mdone) begin
        e_done0 = (owner == 0); e_done1 = (owner == 1);
        e_rdata = mrdata;
        last_port = owner;
        owner = -1;
        free_at = n + GAP + 1;
      end
      e_gnt  = (owner < 0) ? 2'b00 : ((owner == 0) ? 2'b01 : 2'b10);
      e_mreq = (owner >= 0) && legal && (n > grant_edge);
      #1;
      checkOutput("gnt",    32'(gnt),    32'(e_gnt));
      checkOutput("mreq",   32'(mreq),   32'(e_mreq));
      checkOutput("done0",  32'(done0),  32'(e_done0));
      checkOutput("done1",  32'(done1),  32'(e_done1));
      checkOutput("err",    32'(err),    32'(e_err));
      checkOutput("rdata",  32'(rdata),  32'(e_rdata));
      checkOutput("mtype",  32'(mtype),  32'(e_type));
      checkOutput("maddr",  32'(maddr),  32'(e_addr));
      checkOutput("mwdata", 32'(mwdata), 32'(e_wdata));
    end
  end

  initial begin : main
    int         c;
    int         rises_before;
    logic [1:0] seen;

    $display("[TB] reset state");
    repeat (3) @(negedge clk);
    checkOutput("rst_gnt",   32'(gnt),   32'd0);
    checkOutput("rst_mreq",  32'(mreq),  32'd0);
    checkOutput("rst_done",  32'({done1, done0}), 32'd0);
    checkOutput("rst_err",   32'(err),   32'd0);
    checkOutput("rst_rdata", 32'(rdata), 32'd0);
    checkOutput("rst_maddr", 32'(maddr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] tie between both ports");
    applyStimulus(0, MT_RDATA, 16'h0100, 8'h00);
    applyStimulus(1, MT_RDATA, 16'h0200, 8'h00);
    for (int i = 0; i < 4; i++) begin
      waitAnyDone(60, seen);
      checkOutput("tie_order", 32'(seen), (i % 2 == 0) ? 32'd1 : 32'd2);
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (GAP + 3) @(negedge clk);

    $display("[TB] single read");
    fixed_mode = 1'b1; fixed_data = 8'hA5;
    applyStimulus(0, MT_RDATA, 16'h1234, 8'h00);
    waitMreq(20);
    checkOutput("read_maddr", 32'(maddr), 32'h1234);
    waitDone(0, 30, c);
    checkOutput("read_rdata", 32'(rdata), 32'hA5);
    checkOutput("read_err",   32'(err),   32'd0);
    req0 = 1'b0;
    @(negedge clk);
    checkOutput("read_done_one_cycle", 32'(done0), 32'd0);
    repeat (GAP + 3) @(negedge clk);

    $display("[TB] write with input change after grant");
    applyStimulus(1, MT_WCHAR, 16'h2000, 8'h41);
    waitGnt(20);
    wdata1 = 8'hFF;
    waitMreq(20);
    checkOutput("write_mwdata", 32'(mwdata), 32'h41);
    waitDone(1, 30, c);
    checkOutput("write_done0_quiet", 32'(done0), 32'd0);
    req1 = 1'b0;
    repeat (GAP + 3) @(negedge clk);

    $display("[TB] illegal mtype");
    rises_before = rise_count;
    applyStimulus(0, 3'd7, 16'h3000, 8'h00);
    waitDone(0, 20, c);
    checkOutput("illegal_latency", 32'(c), 32'd2);
    checkOutput("illegal_err", 32'(err), 32'd1);
    req0 = 1'b0;
    @(negedge clk);
    applyStimulus(0, MT_WDATA, 16'h3001, 8'h5A);
    waitDone(0, 60, c);
    checkOutput("after_illegal_err", 32'(err), 32'd0);
    checkOutput("illegal_no_mreq", 32'(rise_count - rises_before), 32'd1);
    req0 = 1'b0;
    repeat (GAP + 3) @(negedge clk);

    $display("[TB] stray mdone while idle");
    stray_cnt++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("stray_no_done", 32'({done1, done0}), 32'd0);
      checkOutput("stray_no_gnt",  32'(gnt), 32'd0);
    end

    $display("[TB] reset during WAIT");
    bus_hold = 1'b1;
    applyStimulus(0, MT_RCHAR, 16'h4000, 8'h00);
    waitMreq(20);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstwait_mreq", 32'(mreq), 32'd0);
    checkOutput("rstwait_gnt",  32'(gnt),  32'd0);
    checkOutput("rstwait_done", 32'({done1, done0}), 32'd0);
    checkOutput("rstwait_err",  32'(err),  32'd0);
    req0 = 1'b0;
    @(negedge clk);
    bus_hold = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, MT_RDATA, 16'h5000, 8'h00);
    applyStimulus(1, MT_RDATA, 16'h5001, 8'h00);
    waitAnyDone(60, seen);
    checkOutput("rst_tie_first", 32'(seen), 32'd1);
    waitAnyDone(60, seen);
    checkOutput("rst_tie_second", 32'(seen), 32'd2);
    req0 = 1'b0; req1 = 1'b0;
    repeat (GAP + 3) @(negedge clk);

    $display("[TB] random traffic");
    fixed_mode = 1'b0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clk);
      if (req0 && done0) req0 = 1'b0;
      if (req1 && done1) req1 = 1'b0;
      if (!req0 && $urandom_range(0, 2) == 0)
        applyStimulus(0, 3'($urandom_range(0, 7)), 16'($urandom), 8'($urandom));
      if (!req1 && $urandom_range(0, 2) == 0)
        applyStimulus(1, 3'($urandom_range(0, 7)), 16'($urandom), 8'($urandom));
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("fresh_edges", 32'(rise_count), 32'(legal_issues));

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
